// File: rtl/prim_ram_2p_arb.sv
// Purpose : zero-fills one RAM port after reset, then shares it round-robin among NumReq requesters.
// Latency : grant is combinational (same cycle as req); read data and one-hot rvalid arrive one cycle later.
// Backpres: no grants during the fill; a requester holds req/addr/wdata until it sees its gnt bit.
//
// Ports:
//   clk_i, rst_ni         clock and synchronous active-low reset
//   req_i, write_i        per-requester request and write(1)/read(0)
//   addr_i, wdata_i       packed per-requester address / write data (requester i at slice i)
//   gnt_o, rvalid_o       one-hot grant (same cycle) and one-hot read-data valid (next cycle)
//   rdata_o               shared read data, meaningful only where rvalid_o is set
//   init_done_o           high once the zero-fill has finished
//   mem_*                 RAM port request/write/address/write data, and its read data
module prim_ram_2p_arb #(
  parameter int NumReq = 4,
  parameter int Width  = 32,
  parameter int Depth  = 128,
  parameter int Aw     = $clog2(Depth),
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq-1:0]       write_i,
  input  logic [NumReq*Aw-1:0]    addr_i,
  input  logic [NumReq*Width-1:0] wdata_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       rvalid_o,
  output logic [Width-1:0]        rdata_o,
  output logic                    init_done_o,
  output logic                    mem_req_o,
  output logic                    mem_write_o,
  output logic [Aw-1:0]           mem_addr_o,
  output logic [Width-1:0]        mem_wdata_o,
  input  logic [Width-1:0]        mem_rdata_i
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StArb  = 1'b1;

  logic [0:0]        state;
  logic [Aw-1:0]     init_cnt;
  logic [IdxW-1:0]   ptr;
  logic [NumReq-1:0] rvalid_q;

  logic              gnt_any;
  logic [IdxW-1:0]   gnt_idx;
  logic [NumReq-1:0] gnt;
  logic [NumReq-1:0] rvalid_d;
  logic [IdxW-1:0]   ptr_nxt;
  logic [IdxW:0]     scan_sum;
  logic [IdxW-1:0]   cand;

  logic [Aw-1:0]     addr_arr  [NumReq];
  logic [Width-1:0]  wdata_arr [NumReq];

  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign addr_arr[i]  = addr_i[i*Aw +: Aw];
    assign wdata_arr[i] = wdata_i[i*Width +: Width];
  end

  // Scan ptr, ptr+1, ... modulo NumReq; the first requester found wins.
  // The sum is one bit wider than the pointer so the wrap works for any NumReq.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    cand     = '0;
    if (state == StArb) begin
      for (int k = 0; k < NumReq; k++) begin
        scan_sum = {1'b0, ptr} + (IdxW+1)'(k);
        if (scan_sum >= (IdxW+1)'(NumReq)) begin
          scan_sum = scan_sum - (IdxW+1)'(NumReq);
        end
        cand = scan_sum[IdxW-1:0];
        if (!gnt_any && req_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Only granted reads produce an rvalid pulse; writes complete silently.
  assign rvalid_d = (gnt_any && !write_i[gnt_idx]) ? gnt : '0;

  // Explicit wrap keeps the pointer in range when NumReq is not a power of two.
  assign ptr_nxt = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);

  always_comb begin
    mem_req_o   = 1'b1;
    mem_write_o = 1'b1;
    mem_addr_o  = init_cnt;
    mem_wdata_o = '0;
    if (state == StArb) begin
      mem_req_o   = |req_i;
      mem_write_o = gnt_any & write_i[gnt_idx];
      mem_addr_o  = gnt_any ? addr_arr[gnt_idx] : '0;
      mem_wdata_o = gnt_any ? wdata_arr[gnt_idx] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= StInit;
      init_cnt <= '0;
      ptr      <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      if (state == StInit) begin
        if (init_cnt == Aw'(Depth - 1)) begin
          init_cnt <= '0;
          state    <= StArb;
        end else begin
          init_cnt <= init_cnt + Aw'(1);
        end
      end else if (gnt_any) begin
        ptr <= ptr_nxt;
      end
    end
  end

  assign gnt_o       = gnt;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = mem_rdata_i;
  assign init_done_o = (state == StArb);

endmodule
